wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter sitting directly upstream of the register file: it owns the single register-file write port (write_reg / dstreg_addr / dstreg_data). It merges two result sources onto that port: the in-order pipeline write-back, which has priority, and a long-latency unit (mul/div), which is buffered in a small FIFO behind a valid/ready handshake. It also performs load-data alignment and sign extension, and filters illegal destination addresses.

## Interface
- FIFO_DEPTH, 4, long-latency result buffer entries (power of two, ≥2)
- DATA_W, 32, result width
- ADDR_W, 6, register address width (matches the register-file port)

- clk  in  1  clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- pipe_wb_valid  in  1  pipeline result present this cycle (no back-pressure)
- pipe_wb_addr  in  6  destination register
- pipe_wb_data  in  32  raw result / raw load word
- pipe_wb_is_load  in  1  apply load alignment
- pipe_wb_size  in  2  00 byte, 01 half, 10/11 word
- pipe_wb_signed  in  1  sign-extend byte/half
- pipe_wb_byte_off  in  2  load address [1:0]
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  FIFO can accept
- lu_addr  in  6  destination register
- lu_data  in  32  result
- write_reg  out  1  register-file write enable (registered)
- dstreg_addr  out  6  register-file write address (registered)
- dstreg_data  out  32  register-file write data (registered)
- fifo_count  out  3  FIFO occupancy, 0..FIFO_DEPTH
- err_addr  out  1  sticky illegal-address flag
- rd1_addr, rd2_addr  in  6  read addresses to check (WB_BYPASS_EN only)
- fwd1_hit, fwd2_hit  out  1  forward valid (WB_BYPASS_EN only)
- fwd1_data, fwd2_data  out  32  forward data (WB_BYPASS_EN only)

## Operation
- Address filter (both sources):
  - addr == 0: write silently dropped.
  - addr[5] == 1: write dropped and err_addr set; err_addr stays set until rst.
  - For the LU source, a dropped transfer still completes the handshake but is not pushed.
- Load alignment (is_load = 1):
  - Byte: shifted = data >> (byte_off × 8). Result is shifted[7:0], zero- or sign-extended per pipe_wb_signed.
  - Half: uses byte_off[1] only, selecting data[15:0] or data[31:16], then extends.
  - Word: offset ignored.
  - Non-load results pass through unchanged.
- LU handshake:
  - A transfer occurs when lu_valid && lu_ready.
  - lu_ready = (fifo_count < FIFO_DEPTH) && !rst.
  - No pop credit: when full, ready stays low even if a pop happens in the same cycle.
- Arbitration, evaluated every cycle:
  - A filtered-valid pipe write loads the output register.
  - Otherwise, a non-empty FIFO pops its head into the output register.
  - Otherwise write_reg = 0.
  - The pipe never stalls. A FIFO starved by continuous pipe writes simply waits.
- Push and pop in the same cycle are allowed; count is unchanged.
- FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Pipe path: result presented in cycle N → write_reg/dstreg_* asserted in cycle N+1 → register file written at the end of N+1.
- LU path: minimum 2 cycles. Accepted in N, popped in N+1 if no pipe write, visible on the outputs in N+2.
- Reset values: write_reg 0, dstreg_addr 0, dstreg_data 0, fifo_count 0, err_addr 0, lu_ready 0 while rst is high, FIFO empty.
- Reset asserted mid-operation discards all FIFO contents and any pending write immediately (asynchronous).

## Configuration
- WB_BYPASS_EN defined:
  - fwdN_hit/fwdN_data are combinational.
  - They compare rdN_addr against the output register (when write_reg = 1) and every valid FIFO entry.
  - The youngest FIFO match wins over older entries; any FIFO match wins over the output register.
  - rdN_addr == 0 never hits.
- WB_BYPASS_EN undefined: the rd*/fwd* ports and the compare logic are absent.

## Structure
- Shared package:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
  - ADDR_W / DATA_W constants
  - wb_entry_t {addr, data}
- Sub-module: wb_fifo (parameterised synchronous FIFO, count output, exposes entries for bypass).
- Alignment logic and arbitration stay inline in wb_arbiter.

## Test plan
- Pipe write addr 5, data 0x1234_5678, non-load → next cycle write_reg=1, dstreg_addr=5, dstreg_data=0x1234_5678.
- Load byte, signed, off=2, data 0x0080_0000 → dstreg_data 0xFFFF_FF80. Same with unsigned → 0x0000_0080. Half, off=2, signed, data 0x8001_0000 → 0xFFFF_8001.
- LU pushes 4 results while pipe is continuously valid → lu_ready drops at count 4, no LU writes occur. Pipe goes idle → 4 LU writes in push order on 4 consecutive cycles, count returns to 0.
- Pipe addr 0 → no write; pipe addr 0x21 → no write, err_addr=1 and remains 1 until rst.
- Assert rst with FIFO holding 3 entries and write_reg=1 → write_reg=0 and fifo_count=0 immediately; after deassert there are no stale writes.
- WB_BYPASS_EN: FIFO holds r7=0xA then r7=0xB, rd1_addr=7 → fwd1_hit=1, fwd1_data=0xB. rd2_addr=0 → fwd2_hit=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the write-back arbiter and its result FIFO.
// Load size encodings, default widths and the buffered long-latency entry.
package wb_arbiter_pkg;

    localparam int WB_ADDR_W = 6;
    localparam int WB_DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } wb_size_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    // The top address bit marks a register outside the file; zero is the hardwired zero register.
    function automatic logic addr_is_illegal(input logic [WB_ADDR_W-1:0] addr);
        return addr[WB_ADDR_W-1];
    endfunction

    function automatic logic addr_is_writable(input logic [WB_ADDR_W-1:0] addr);
        return (addr != '0) && !addr[WB_ADDR_W-1];
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO for long-latency write-backs.
// Exposes its storage and read pointer so the owner can read the head and search entries.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  wb_entry_t        i_push_entry,
    input  logic             i_pop,
    output logic [CNT_W-1:0] o_count,
    output logic [PTR_W-1:0] o_rd_ptr,
    output wb_entry_t        o_entries [DEPTH]
);

    wb_entry_t        r_entries [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_entries[r_wr_ptr] <= i_push_entry;
                r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_entries = r_entries;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter owning the register-file write port: pipeline results first, buffered
// long-latency results otherwise. Optional forwarding compare is built when WB_BYPASS_EN is defined.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_wb_valid,
    input  logic [ADDR_W-1:0] pipe_wb_addr,
    input  logic [DATA_W-1:0] pipe_wb_data,
    input  logic              pipe_wb_is_load,
    input  logic [1:0]        pipe_wb_size,
    input  logic              pipe_wb_signed,
    input  logic [1:0]        pipe_wb_byte_off,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0] lu_data,
    output logic              write_reg,
    output logic [ADDR_W-1:0] dstreg_addr,
    output logic [DATA_W-1:0] dstreg_data,
    output logic [CNT_W-1:0]  fifo_count,
    output logic              err_addr
`ifdef WB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0] rd1_addr,
    input  logic [ADDR_W-1:0] rd2_addr,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [DATA_W-1:0] fwd1_data,
    output logic [DATA_W-1:0] fwd2_data
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic              r_write_reg;
    logic [ADDR_W-1:0] r_dstreg_addr;
    logic [DATA_W-1:0] r_dstreg_data;
    logic              r_err_addr;

    logic              w_pipe_write;
    logic              w_pipe_illegal;
    logic              w_lu_fire;
    logic              w_lu_push;
    logic              w_lu_illegal;
    logic              w_pop;
    logic [DATA_W-1:0] w_aligned;
    logic [DATA_W-1:0] w_shifted;
    logic [15:0]       w_half;
    logic [CNT_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_rd_ptr;
    wb_entry_t         w_entries [FIFO_DEPTH];
    wb_entry_t         w_head;
    wb_entry_t         w_push_entry;

    assign w_pipe_write   = pipe_wb_valid && addr_is_writable(pipe_wb_addr);
    assign w_pipe_illegal = pipe_wb_valid && addr_is_illegal(pipe_wb_addr);

    // A transfer to an unwritable register still completes the handshake; it just never enters the FIFO.
    assign lu_ready     = (w_count < CNT_W'(FIFO_DEPTH)) && !rst;
    assign w_lu_fire    = lu_valid && lu_ready;
    assign w_lu_push    = w_lu_fire && addr_is_writable(lu_addr);
    assign w_lu_illegal = w_lu_fire && addr_is_illegal(lu_addr);
    assign w_push_entry = '{addr: lu_addr, data: lu_data};

    assign w_pop  = !w_pipe_write && (w_count != '0);
    assign w_head = w_entries[w_rd_ptr];

    wb_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_lu_push),
        .i_push_entry(w_push_entry),
        .i_pop       (w_pop),
        .o_count     (w_count),
        .o_rd_ptr    (w_rd_ptr),
        .o_entries   (w_entries)
    );

    assign w_shifted = pipe_wb_data >> {pipe_wb_byte_off, 3'b000};
    assign w_half    = pipe_wb_byte_off[1] ? pipe_wb_data[31:16] : pipe_wb_data[15:0];

    always_comb begin
        w_aligned = pipe_wb_data;
        if (pipe_wb_is_load) begin
            case (pipe_wb_size)
                SZ_BYTE: w_aligned = {{(DATA_W-8){pipe_wb_signed & w_shifted[7]}}, w_shifted[7:0]};
                SZ_HALF: w_aligned = {{(DATA_W-16){pipe_wb_signed & w_half[15]}}, w_half};
                default: w_aligned = pipe_wb_data;
            endcase
        end
    end

    // Address and data hold their last value when no write is issued; only the enable drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write_reg   <= 1'b0;
            r_dstreg_addr <= '0;
            r_dstreg_data <= '0;
        end else if (w_pipe_write) begin
            r_write_reg   <= 1'b1;
            r_dstreg_addr <= pipe_wb_addr;
            r_dstreg_data <= w_aligned;
        end else if (w_pop) begin
            r_write_reg   <= 1'b1;
            r_dstreg_addr <= w_head.addr;
            r_dstreg_data <= w_head.data;
        end else begin
            r_write_reg   <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_addr <= 1'b0;
        end else if (w_pipe_illegal || w_lu_illegal) begin
            r_err_addr <= 1'b1;
        end
    end

    assign write_reg   = r_write_reg;
    assign dstreg_addr = r_dstreg_addr;
    assign dstreg_data = r_dstreg_data;
    assign fifo_count  = w_count;
    assign err_addr    = r_err_addr;

`ifdef WB_BYPASS_EN
    logic [ADDR_W-1:0] w_rd_addr  [2];
    logic              w_fwd_hit  [2];
    logic [DATA_W-1:0] w_fwd_data [2];

    assign w_rd_addr[0] = rd1_addr;
    assign w_rd_addr[1] = rd2_addr;

    // Scan oldest to youngest so the youngest FIFO match overrides, and any FIFO match beats the output register.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_fwd_hit[p]  = 1'b0;
            w_fwd_data[p] = '0;
            if (w_rd_addr[p] != '0) begin
                if (r_write_reg && (r_dstreg_addr == w_rd_addr[p])) begin
                    w_fwd_hit[p]  = 1'b1;
                    w_fwd_data[p] = r_dstreg_data;
                end
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    if ((CNT_W'(i) < w_count) &&
                        (w_entries[w_rd_ptr + PTR_W'(i)].addr == w_rd_addr[p])) begin
                        w_fwd_hit[p]  = 1'b1;
                        w_fwd_data[p] = w_entries[w_rd_ptr + PTR_W'(i)].data;
                    end
                end
            end
        end
    end

    assign fwd1_hit  = w_fwd_hit[0];
    assign fwd2_hit  = w_fwd_hit[1];
    assign fwd1_data = w_fwd_data[0];
    assign fwd2_data = w_fwd_data[1];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected writes, a monitor retires them.
// Forwarding checks are included when WB_BYPASS_EN is defined.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_wb_valid;
    logic [5:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        pipe_wb_is_load;
    logic [1:0]  pipe_wb_size;
    logic        pipe_wb_signed;
    logic [1:0]  pipe_wb_byte_off;
    logic        lu_valid;
    logic        lu_ready;
    logic [5:0]  lu_addr;
    logic [31:0] lu_data;
    logic        write_reg;
    logic [5:0]  dstreg_addr;
    logic [31:0] dstreg_data;
    logic [2:0]  fifo_count;
    logic        err_addr;
`ifdef WB_BYPASS_EN
    logic [5:0]  rd1_addr;
    logic [5:0]  rd2_addr;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd1_data;
    logic [31:0] fwd2_data;
`endif

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t expQ[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    wb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .pipe_wb_valid   (pipe_wb_valid),
        .pipe_wb_addr    (pipe_wb_addr),
        .pipe_wb_data    (pipe_wb_data),
        .pipe_wb_is_load (pipe_wb_is_load),
        .pipe_wb_size    (pipe_wb_size),
        .pipe_wb_signed  (pipe_wb_signed),
        .pipe_wb_byte_off(pipe_wb_byte_off),
        .lu_valid        (lu_valid),
        .lu_ready        (lu_ready),
        .lu_addr         (lu_addr),
        .lu_data         (lu_data),
        .write_reg       (write_reg),
        .dstreg_addr     (dstreg_addr),
        .dstreg_data     (dstreg_data),
        .fifo_count      (fifo_count),
        .err_addr        (err_addr)
`ifdef WB_BYPASS_EN
        ,
        .rd1_addr        (rd1_addr),
        .rd2_addr        (rd2_addr),
        .fwd1_hit        (fwd1_hit),
        .fwd2_hit        (fwd2_hit),
        .fwd1_data       (fwd1_data),
        .fwd2_data       (fwd2_data)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Retires one expected write per observed write; also flags writes that never arrived on time.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            if (write_reg) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_write: cycle %0d got addr %0d data %h, required no write",
                             cyc, dstreg_addr, dstreg_data);
                end else begin
                    e = expQ.pop_front();
                    if (dstreg_addr !== e.addr || dstreg_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("[TB] FAIL write: got addr %0d data %h cycle %0d, required addr %0d data %h cycle %0d",
                                 dstreg_addr, dstreg_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end else if (expQ.size() != 0 && expQ[0].cyc <= cyc) begin
                e = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed_write: cycle %0d no write, required addr %0d data %h at cycle %0d",
                         cyc, e.addr, e.data, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [5:0] addr, input logic [31:0] data, input int c);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = c;
        expQ.push_back(e);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    // Drives one pipeline result for one cycle; the write is expected on the following cycle.
    task automatic applyStimulus(input logic [5:0] addr, input logic [31:0] data, input logic isLoad,
                                 input logic [1:0] size, input logic sgn, input logic [1:0] off,
                                 input logic expWrite, input logic [31:0] expData);
        pipe_wb_valid    = 1'b1;
        pipe_wb_addr     = addr;
        pipe_wb_data     = data;
        pipe_wb_is_load  = isLoad;
        pipe_wb_size     = size;
        pipe_wb_signed   = sgn;
        pipe_wb_byte_off = off;
        if (expWrite) pushExp(addr, expData, cyc + 1);
        tick();
    endtask

    task automatic pipeIdle();
        pipe_wb_valid = 1'b0;
        tick();
    endtask

    initial begin
        int c;
        rst              = 1'b1;
        pipe_wb_valid    = 1'b0;
        pipe_wb_addr     = '0;
        pipe_wb_data     = '0;
        pipe_wb_is_load  = 1'b0;
        pipe_wb_size     = 2'b10;
        pipe_wb_signed   = 1'b0;
        pipe_wb_byte_off = '0;
        lu_valid         = 1'b0;
        lu_addr          = '0;
        lu_data          = '0;
`ifdef WB_BYPASS_EN
        rd1_addr         = '0;
        rd2_addr         = '0;
`endif
        #12;
        checkOutput("reset_write_reg", 32'(write_reg), 32'h0);
        checkOutput("reset_dstreg_addr", 32'(dstreg_addr), 32'h0);
        checkOutput("reset_dstreg_data", dstreg_data, 32'h0);
        checkOutput("reset_fifo_count", 32'(fifo_count), 32'h0);
        checkOutput("reset_err_addr", 32'(err_addr), 32'h0);
        checkOutput("reset_lu_ready", 32'(lu_ready), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("lu_ready_after_reset", 32'(lu_ready), 32'h1);

        applyStimulus(6'd5,  32'h1234_5678, 1'b0, 2'b10, 1'b0, 2'd0, 1'b1, 32'h1234_5678);
        applyStimulus(6'd6,  32'h0080_0000, 1'b1, 2'b00, 1'b1, 2'd2, 1'b1, 32'hFFFF_FF80);
        applyStimulus(6'd7,  32'h0080_0000, 1'b1, 2'b00, 1'b0, 2'd2, 1'b1, 32'h0000_0080);
        applyStimulus(6'd8,  32'h8001_0000, 1'b1, 2'b01, 1'b1, 2'd2, 1'b1, 32'hFFFF_8001);
        applyStimulus(6'd9,  32'hAB00_0000, 1'b1, 2'b00, 1'b0, 2'd3, 1'b1, 32'h0000_00AB);
        applyStimulus(6'd10, 32'h1234_8001, 1'b1, 2'b01, 1'b0, 2'd0, 1'b1, 32'h0000_8001);
        applyStimulus(6'd11, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b1, 2'd1, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(6'd12, 32'h0000_007F, 1'b1, 2'b00, 1'b1, 2'd0, 1'b1, 32'h0000_007F);
        applyStimulus(6'd13, 32'hCAFE_F00D, 1'b0, 2'b00, 1'b1, 2'd1, 1'b1, 32'hCAFE_F00D);
        applyStimulus(6'd31, 32'h0000_8000, 1'b1, 2'b11, 1'b1, 2'd2, 1'b1, 32'h0000_8000);
        applyStimulus(6'd0,  32'h5555_5555, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0);
        pipeIdle();
        checkOutput("err_after_addr0", 32'(err_addr), 32'h0);
        applyStimulus(6'h21, 32'h6666_6666, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0);
        checkOutput("err_after_addr21", 32'(err_addr), 32'h1);
        pipeIdle();
        pipeIdle();
        checkOutput("err_sticky", 32'(err_addr), 32'h1);

        // FIFO fills while the pipe hogs the port, then drains in order once the pipe goes idle.
        for (int i = 0; i < 6; i++) begin
            c = (i < 4) ? i : 4;
            lu_valid = 1'b1;
            lu_addr  = 6'(20 + c);
            lu_data  = 32'(32'hA0 + c);
            checkOutput($sformatf("fill_lu_ready_%0d", i), 32'(lu_ready), (i < 4) ? 32'h1 : 32'h0);
            checkOutput($sformatf("fill_count_%0d", i), 32'(fifo_count), 32'(c));
            applyStimulus(6'(14 + i), 32'(32'h100 + i), 1'b0, 2'b10, 1'b0, 2'd0, 1'b1, 32'(32'h100 + i));
        end
        lu_valid = 1'b0;
        pipe_wb_valid = 1'b0;
        for (int j = 0; j < 4; j++) pushExp(6'(20 + j), 32'(32'hA0 + j), cyc + 1 + j);
        for (int j = 0; j < 5; j++) tick();
        checkOutput("drain_count", 32'(fifo_count), 32'h0);

        // One LU result per cycle with an idle pipe: push and pop coincide, so occupancy stays at one.
        for (int d = 0; d < 3; d++) begin
            lu_valid = 1'b1;
            lu_addr  = 6'(26 + d);
            lu_data  = 32'(32'hB0 + d);
            checkOutput($sformatf("stream_count_%0d", d), 32'(fifo_count), (d == 0) ? 32'h0 : 32'h1);
            pushExp(6'(26 + d), 32'(32'hB0 + d), cyc + 2);
            tick();
        end
        lu_valid = 1'b0;
        tick();
        checkOutput("stream_count_end", 32'(fifo_count), 32'h0);
        tick();

        // Reset mid-operation with three buffered entries and a write in flight.
        for (int i = 0; i < 3; i++) begin
            lu_valid = 1'b1;
            lu_addr  = 6'(8 + i);
            lu_data  = 32'(32'h300 + i);
            applyStimulus(6'(1 + i), 32'(32'h200 + i), 1'b0, 2'b10, 1'b0, 2'd0, 1'b1, 32'(32'h200 + i));
        end
        lu_valid = 1'b0;
        applyStimulus(6'd4, 32'h0000_0204, 1'b0, 2'b10, 1'b0, 2'd0, 1'b0, 32'h0);
        checkOutput("pre_reset_write_reg", 32'(write_reg), 32'h1);
        checkOutput("pre_reset_count", 32'(fifo_count), 32'h3);
        rst = 1'b1;
        pipe_wb_valid = 1'b0;
        #1;
        checkOutput("async_reset_write_reg", 32'(write_reg), 32'h0);
        checkOutput("async_reset_count", 32'(fifo_count), 32'h0);
        checkOutput("async_reset_lu_ready", 32'(lu_ready), 32'h0);
        checkOutput("async_reset_err", 32'(err_addr), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 6; j++) tick();

        // Long-latency results to unwritable registers handshake but never buffer.
        lu_valid = 1'b1;
        lu_addr  = 6'h22;
        lu_data  = 32'hDEAD_0001;
        checkOutput("lu_illegal_ready", 32'(lu_ready), 32'h1);
        tick();
        checkOutput("lu_illegal_count", 32'(fifo_count), 32'h0);
        checkOutput("lu_illegal_err", 32'(err_addr), 32'h1);
        lu_addr = 6'h00;
        tick();
        lu_valid = 1'b0;
        checkOutput("lu_zero_count", 32'(fifo_count), 32'h0);
        tick();

`ifdef WB_BYPASS_EN
        lu_valid = 1'b1;
        lu_addr  = 6'd7;
        lu_data  = 32'h0000_000A;
        applyStimulus(6'd3, 32'h0000_0400, 1'b0, 2'b10, 1'b0, 2'd0, 1'b1, 32'h0000_0400);
        lu_data  = 32'h0000_000B;
        applyStimulus(6'd4, 32'h0000_0401, 1'b0, 2'b10, 1'b0, 2'd0, 1'b1, 32'h0000_0401);
        lu_valid = 1'b0;
        rd1_addr = 6'd7;
        rd2_addr = 6'd0;
        #1;
        checkOutput("fwd1_hit_young", 32'(fwd1_hit), 32'h1);
        checkOutput("fwd1_data_young", fwd1_data, 32'h0000_000B);
        checkOutput("fwd2_hit_zero", 32'(fwd2_hit), 32'h0);
        rd2_addr = 6'd4;
        #1;
        checkOutput("fwd2_hit_outreg", 32'(fwd2_hit), 32'h1);
        checkOutput("fwd2_data_outreg", fwd2_data, 32'h0000_0401);
        pipe_wb_valid = 1'b0;
        pushExp(6'd7, 32'h0000_000A, cyc + 1);
        pushExp(6'd7, 32'h0000_000B, cyc + 2);
        for (int j = 0; j < 4; j++) tick();
        rd1_addr = '0;
        rd2_addr = '0;
`endif

        tick();
        tick();
        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
